// File: rtl/audio_i2s_out_pkg.sv
// Shared audio-path constants: sample/slot geometry of the I2S frame and the
// 16-bit saturation limits used by every mixer stage.
package audio_i2s_out_pkg;

    localparam int unsigned AUDIO_SAMPLE_W      = 16;
    localparam int unsigned I2S_SLOT_W          = 32;
    localparam int unsigned I2S_SLOTS_PER_FRAME = 64;

    localparam logic [AUDIO_SAMPLE_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [AUDIO_SAMPLE_W-1:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/audio_sat_add.sv
// Combinational signed 16+16 add, clamped to the 16-bit signed range.
module audio_sat_add
    import audio_i2s_out_pkg::*;
(
    input  logic [AUDIO_SAMPLE_W-1:0] a,
    input  logic [AUDIO_SAMPLE_W-1:0] b,
    output logic [AUDIO_SAMPLE_W-1:0] y
);

    logic [AUDIO_SAMPLE_W:0] sum;

    always_comb begin
        sum = {a[AUDIO_SAMPLE_W-1], a} + {b[AUDIO_SAMPLE_W-1], b};
        // Disagreeing top two bits mean the true result left the 16-bit range.
        if (sum[AUDIO_SAMPLE_W] != sum[AUDIO_SAMPLE_W-1])
            y = sum[AUDIO_SAMPLE_W] ? SAT_MIN : SAT_MAX;
        else
            y = sum[AUDIO_SAMPLE_W-1:0];
    end

endmodule

// File: rtl/audio_i2s_out.sv
// Audio output stage: mixes PSG and PCM stereo samples, serialises them as
// standard I2S and generates the per-frame next_sample strobe.
module audio_i2s_out
    import audio_i2s_out_pkg::*;
#(
    parameter int unsigned BCK_DIV_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] psg_left,
    input  logic [15:0] psg_right,
    input  logic [15:0] pcm_left,
    input  logic [15:0] pcm_right,
    output logic        next_sample,
    output logic        i2s_lrck,
    output logic        i2s_bck,
    output logic        i2s_data
);

    localparam int unsigned W = BCK_DIV_LOG2 + 7;

    logic [W-1:0]                cnt;
    logic                        half;
    logic [4:0]                  k;
    logic [4:0]                  bit_idx;
    logic [AUDIO_SAMPLE_W-1:0]   word;
    logic [AUDIO_SAMPLE_W-1:0]   mix_left;
    logic [AUDIO_SAMPLE_W-1:0]   mix_right;
    logic [AUDIO_SAMPLE_W-1:0]   left_lat;
    logic [AUDIO_SAMPLE_W-1:0]   right_lat;
    logic                        data_next;
    logic                        frame_end;

    audio_sat_add u_sat_left (
        .a (psg_left),
        .b (pcm_left),
        .y (mix_left)
    );

    audio_sat_add u_sat_right (
        .a (psg_right),
        .b (pcm_right),
        .y (mix_right)
    );

    // Slot-in-half is the low five bits of the slot field cnt[W-1:BCK_DIV_LOG2+1].
    assign half      = cnt[W-1];
    assign k         = cnt[W-2 -: 5];
    assign frame_end = (cnt == '1);

    always_comb begin
        word      = half ? right_lat : left_lat;
        bit_idx   = 5'd16 - k;
        data_next = 1'b0;
        if (k >= 5'd1 && k <= 5'd16)
            data_next = word[bit_idx[3:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            left_lat    <= '0;
            right_lat   <= '0;
            next_sample <= 1'b0;
            i2s_bck     <= 1'b0;
            i2s_lrck    <= 1'b0;
            i2s_data    <= 1'b0;
        end else begin
            cnt         <= cnt + W'(1);
            next_sample <= frame_end;
            i2s_bck     <= cnt[BCK_DIV_LOG2];
            i2s_lrck    <= half;
            i2s_data    <= data_next;
            if (frame_end) begin
                left_lat  <= mix_left;
                right_lat <= mix_right;
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_out.sv
// Directed bench for audio_i2s_out: vector table of mixed samples, plus
// reset, frame-hold and mid-frame reset sequences.
module tb_audio_i2s_out;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] psg_left, psg_right, pcm_left, pcm_right;
    logic        next_sample, i2s_lrck, i2s_bck, i2s_data;

    int n_cmp  = 0;
    int n_fail = 0;

    audio_i2s_out #(.BCK_DIV_LOG2(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .psg_left    (psg_left),
        .psg_right   (psg_right),
        .pcm_left    (pcm_left),
        .pcm_right   (pcm_right),
        .next_sample (next_sample),
        .i2s_lrck    (i2s_lrck),
        .i2s_bck     (i2s_bck),
        .i2s_data    (i2s_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pl, pr, ml, mr;
        logic [15:0] exp_l, exp_r;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One frame starting at the sample just after a latch edge (or reset release).
    // Iteration i observes the outputs decoded from cnt == i.
    task automatic capture(input logic chg_en, input logic [15:0] chg_val,
                           output logic [15:0] wl, output logic [15:0] wr,
                           output int errs);
        logic [8:0] idx;
        logic [4:0] kk;
        logic       cur;
        wl   = '0;
        wr   = '0;
        errs = 0;
        cur  = 1'b0;
        for (int i = 0; i < 512; i++) begin
            @(posedge clk);
            #1;
            idx = 9'(i);
            if (chg_en && i == 99) psg_left = chg_val;
            if (i2s_bck !== idx[2]) errs++;
            if (i2s_lrck !== idx[8]) errs++;
            if (next_sample !== (i == 511)) errs++;
            if (idx[2:0] == 3'd0) cur = i2s_data;
            else if (i2s_data !== cur) errs++;
            if (idx[2:0] == 3'd4) begin
                kk = idx[7:3];
                if (kk >= 5'd1 && kk <= 5'd16) begin
                    if (!idx[8]) wl[5'd16 - kk] = i2s_data;
                    else         wr[5'd16 - kk] = i2s_data;
                end else if (i2s_data !== 1'b0) begin
                    errs++;
                end
            end
        end
    endtask

    initial begin
        logic [15:0] wl, wr;
        int          errs;

        vecs[0] = '{16'h1234, 16'hABCD, 16'h0000, 16'h0000, 16'h1234, 16'hABCD};
        vecs[1] = '{16'h7000, 16'h9000, 16'h2000, 16'hE000, 16'h7FFF, 16'h8000};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001, 16'h0000, 16'h0000};
        vecs[3] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
        vecs[4] = '{16'h1000, 16'h0100, 16'hE000, 16'h0023, 16'hF000, 16'h0123};
        vecs[5] = '{16'h4000, 16'hC000, 16'h3FFF, 16'hC000, 16'h7FFF, 16'h8000};
        vecs[6] = '{16'h4000, 16'hC000, 16'h4000, 16'hBFFF, 16'h7FFF, 16'h8000};
        vecs[7] = '{16'h8001, 16'h5555, 16'hFFFF, 16'h2AAA, 16'h8000, 16'h7FFF};

        psg_left = '0; psg_right = '0; pcm_left = '0; pcm_right = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {28'd0, next_sample, i2s_bck, i2s_lrck, i2s_data}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        capture(1'b0, 16'h0, wl, wr, errs);
        check("first_frame_shape", errs, 0);
        check("first_frame_words", {wl, wr}, 32'd0);

        for (int v = 0; v < 8; v++) begin
            psg_left  = vecs[v].pl;
            psg_right = vecs[v].pr;
            pcm_left  = vecs[v].ml;
            pcm_right = vecs[v].mr;
            capture(1'b0, 16'h0, wl, wr, errs);
            check("vec_latch_frame_shape", errs, 0);
            capture(1'b0, 16'h0, wl, wr, errs);
            check("vec_shape", errs, 0);
            check("vec_left", {16'd0, wl}, {16'd0, vecs[v].exp_l});
            check("vec_right", {16'd0, wr}, {16'd0, vecs[v].exp_r});
        end

        psg_left = 16'h0F0F; psg_right = 16'h0000; pcm_left = 16'h0000; pcm_right = 16'h0000;
        capture(1'b0, 16'h0, wl, wr, errs);
        capture(1'b1, 16'hF0F0, wl, wr, errs);
        check("hold_shape", errs, 0);
        check("hold_current_frame", {16'd0, wl}, 32'h0F0F);
        capture(1'b0, 16'h0, wl, wr, errs);
        check("hold_next_frame", {16'd0, wl}, 32'hF0F0);

        psg_left = 16'h1111; psg_right = 16'h2222;
        capture(1'b0, 16'h0, wl, wr, errs);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_right_half", {31'd0, i2s_lrck}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {28'd0, next_sample, i2s_bck, i2s_lrck, i2s_data}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("held_reset_outputs", {28'd0, next_sample, i2s_bck, i2s_lrck, i2s_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        capture(1'b0, 16'h0, wl, wr, errs);
        check("post_reset_shape", errs, 0);
        check("post_reset_words", {wl, wr}, 32'd0);
        capture(1'b0, 16'h0, wl, wr, errs);
        check("post_reset_relatch", {wl, wr}, 32'h1111_2222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
